// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access controller: turns loads/stores into req/ack bus
// transactions, stalls the pipeline until done, and flags bus timeouts.
module mem_access_stage #(
    parameter int          ADDR_W   = 22,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic              flush,
    input  logic              MEM_mem_read,
    input  logic              MEM_mem_write,
    input  logic [31:0]       MEM_ALU_result,
    input  logic [31:0]       MEM_store_data,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [31:0]       MEM_mem_result,
    output logic              mem_stall,
    output logic              mem_err,
    output logic [1:0]        dbg_state_o
);

    // Bus handshake: mem_req rises when an access is issued and stays high,
    // with addr/we/wdata stable, until the cycle mem_ack is sampled (or the
    // timeout expires); mem_ack is a one-cycle pulse ignored outside WAIT/DRAIN.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       result_q, result_d;
    logic              err_q, err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              access;
    logic              expired;

    assign access  = MEM_mem_read | MEM_mem_write;
    assign expired = (cnt_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access && !flush) begin
                    mem_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = MEM_mem_write;
                    addr_d    = MEM_ALU_result[ADDR_W-1:0];
                    wdata_d   = MEM_store_data;
                    cnt_d     = 8'd0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                mem_stall = 1'b1;
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        if (!we_q) result_d = mem_rdata;
                        state_d = S_DONE;
                    end
                end else if (expired) begin
                    // A flushed instruction must not see ERR_DATA either.
                    req_d = 1'b0;
                    err_d = 1'b1;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        if (!we_q) result_d = ERR_DATA;
                        state_d = S_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (flush) state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                if (flush || !hlt) state_d = S_IDLE;
            end
            S_DRAIN: begin
                // The counter keeps running from WAIT so the bus budget is total.
                mem_stall = 1'b1;
                if (mem_ack) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end else if (expired) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            result_q <= result_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign mem_req        = req_q;
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign MEM_mem_result = result_q;
    assign mem_err        = err_q;
    assign dbg_state_o    = state_q;

endmodule
